// File: rtl/spim_trace_capture_if.sv
// Trace capture bus: spim debug trace inputs, record stream handshake and status.
// The slave modport is the capture block; the master side drives the core trace.
interface spim_trace_capture_if;
  logic        capture_en;
  logic [9:0]  cpu_pc;
  logic [31:0] cpu_instruction;
  logic [31:0] cpu_alu_result;
  logic [3:0]  cpu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_record;
  logic        halted;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [15:0] sample_count;

  modport master (
    output capture_en, cpu_pc, cpu_instruction, cpu_alu_result, cpu_flags, out_ready,
    input  out_valid, out_record, halted, overflow, drop_count, sample_count
  );

  modport slave (
    input  capture_en, cpu_pc, cpu_instruction, cpu_alu_result, cpu_flags, out_ready,
    output out_valid, out_record, halted, overflow, drop_count, sample_count
  );
endinterface

// File: rtl/spim_trace_capture.sv
// Trace capture for the spim core: samples the debug bus while enabled, queues
// records in a small FIFO and declares a halt when the PC stops advancing.
module spim_trace_capture #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HALT_CYCLES = 4
) (
  input logic                 clk,
  input logic                 reset,
  spim_trace_capture_if.slave trace_if
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RW  = 78;
  localparam int unsigned HCW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam logic [HCW-1:0] HALT_LAST = HCW'(HALT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALTED  = 2'd2
  } state_e;

  state_e         state_q;
  logic [HCW-1:0] halt_cnt_q;
  logic [HCW-1:0] halt_next_s;
  logic [9:0]     prev_pc_q;
  logic           prev_vld_q;
  logic           halted_q;
  logic [RW-1:0]  stage_q;
  logic           stage_vld_q;
  logic [RW-1:0]  trace_s;

  logic [RW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  rd_ptr_d;
  logic           overflow_q;
  logic           overflow_d;
  logic [7:0]     drop_cnt_q;
  logic [7:0]     drop_cnt_d;
  logic [15:0]    sample_cnt_q;
  logic [15:0]    sample_cnt_d;
  logic           empty_s;
  logic           full_s;
  logic           pop_s;
  logic           push_s;
  logic           drop_s;

  assign trace_s = {trace_if.cpu_pc, trace_if.cpu_instruction,
                    trace_if.cpu_alu_result, trace_if.cpu_flags};

  // Halt counter value after the current sample: grows on a repeated PC, else restarts.
  always_comb begin
    halt_next_s = '0;
    if (prev_vld_q && (trace_if.cpu_pc == prev_pc_q)) begin
      halt_next_s = halt_cnt_q + HCW'(1);
    end else begin
      halt_next_s = '0;
    end
  end

  // Capture FSM; a sample waits one cycle in stage_q before entering the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      halt_cnt_q  <= '0;
      prev_pc_q   <= 10'd0;
      prev_vld_q  <= 1'b0;
      halted_q    <= 1'b0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      stage_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trace_if.capture_en) begin
            state_q    <= CAPTURE;
            halt_cnt_q <= '0;
            prev_vld_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (!trace_if.capture_en) begin
            state_q <= IDLE;
          end else begin
            stage_q     <= trace_s;
            stage_vld_q <= 1'b1;
            prev_pc_q   <= trace_if.cpu_pc;
            prev_vld_q  <= 1'b1;
            halt_cnt_q  <= halt_next_s;
            if (halt_next_s == HALT_LAST) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!trace_if.capture_en) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control: a pop frees the slot so a push on a full FIFO still lands.
  always_comb begin
    empty_s      = (wr_ptr_q == rd_ptr_q);
    full_s       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s        = !empty_s && trace_if.out_ready;
    push_s       = stage_vld_q && (!full_s || pop_s);
    drop_s       = stage_vld_q && full_s && !pop_s;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    sample_cnt_d = sample_cnt_q;
    if (push_s) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      sample_cnt_d = sample_cnt_q + 16'd1;
    end else begin
      wr_ptr_d     = wr_ptr_q;
      sample_cnt_d = sample_cnt_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : (drop_cnt_q + 8'd1);
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // FIFO pointers and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
      sample_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Record storage; left unreset because the read side is gated by empty_s.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= stage_q;
    end
  end

  assign trace_if.out_valid    = !empty_s;
  assign trace_if.out_record   = empty_s ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign trace_if.halted       = halted_q;
  assign trace_if.overflow     = overflow_q;
  assign trace_if.drop_count   = drop_cnt_q;
  assign trace_if.sample_count = sample_cnt_q;

endmodule

// File: doc/spim_trace_capture.md
SPIM_TRACE_CAPTURE -- requirements
Module: spim_trace_capture

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, at least 2.
REQ-002 Parameter HALT_CYCLES, default 4, number of consecutive equal-PC samples that declares a halt.
REQ-003 clk  input  1  rising-edge clock, same clock as the spim core.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 capture_en  input  1  enables sampling of the core trace bus.
REQ-006 cpu_pc  input  10  core PC debug output.
REQ-007 cpu_instruction  input  32  core instruction debug output.
REQ-008 cpu_alu_result  input  32  core ALU result debug output.
REQ-009 cpu_flags  input  4  {branch, zero, memwrite, regwrite} from the core.
REQ-010 out_valid  output  1  a trace record is presented.
REQ-011 out_ready  input  1  the consumer accepts the record.
REQ-012 out_record  output  78  {pc[77:68], instruction[67:36], alu_result[35:4], flags[3:0]}.
REQ-013 halted  output  1  halt detected; high while the state is HALTED.
REQ-014 overflow  output  1  sticky: at least one sample was dropped.
REQ-015 drop_count  output  8  number of dropped samples, saturating at 255.
REQ-016 sample_count  output  16  number of samples accepted into the FIFO, wraps modulo 2^16.

Function
REQ-017 The FSM SHALL have three states: IDLE, CAPTURE and HALTED.
REQ-018 IDLE->CAPTURE SHALL occur on the first rising edge at which capture_en=1; no sample is taken on that edge.
REQ-019 In CAPTURE, every rising edge SHALL produce one sample of the trace bus, pushed to the FIFO if it is not full.
REQ-020 CAPTURE->IDLE SHALL occur on the first edge at which capture_en=0; no sample is taken on that edge.
REQ-021 The halt counter SHALL count consecutive samples whose cpu_pc equals the previous sample's PC; it clears on a PC change and on entry to CAPTURE.
REQ-022 When the halt counter reaches HALT_CYCLES-1, the FSM SHALL move CAPTURE->HALTED; the sample that completes the count is pushed, and sampling stops after it.
REQ-023 HALTED->IDLE SHALL occur only when capture_en=0; HALTED is not left while capture_en stays high.
REQ-024 Sample latency: a sample taken at edge N SHALL be visible on out_record, with out_valid=1, after edge N+1 at the earliest (registered FIFO, no bypass).
REQ-025 A pop SHALL occur when out_valid=1 and out_ready=1 at a rising edge; out_record SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When the FIFO is full and a pop occurs on the same edge, a concurrent push SHALL be accepted; occupancy is unchanged.
REQ-027 When the FIFO is full with no pop, a sample SHALL be dropped: overflow is set, drop_count increments (saturating at 255), sample_count holds.
REQ-028 When the FIFO is empty, out_valid SHALL be 0; a pop attempted while empty has no effect.
REQ-029 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are derived from the pointer MSB and the remaining bits.
REQ-030 FIFO drain SHALL continue in every state, including IDLE and HALTED.
REQ-031 Counters and flags SHALL change only on the clock edge; all outputs are registered or decoded from registers.

Reset
REQ-032 Asserting reset (low) SHALL asynchronously force: state IDLE, FIFO empty, out_valid=0, out_record=0, halted=0, overflow=0, drop_count=0, sample_count=0, halt counter=0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents; no partial record is ever presented.
REQ-034 Reset release SHALL be followed by at least one IDLE cycle before any sample is taken.

Verification
REQ-035 Reset, capture_en=1, out_ready=1, PC stepping 0,4,8,... -> records appear one cycle after sampling with matching PC, sample_count increments by 1 per cycle, overflow=0.
REQ-036 out_ready=0, 12 samples with distinct PCs -> first 8 records retained, overflow=1, drop_count=4, sample_count=8; then out_ready=1 -> the 8 records drain in order.
REQ-037 FIFO full, out_ready=1, sampling continues -> no drops, occupancy stays 8, drop_count is unchanged.
REQ-038 PC held at 0x020 for 4 samples -> halted=1 after the 4th sample, exactly 4 records with PC 0x020, no further samples; capture_en=0 -> IDLE and halted=0.
REQ-039 Reset pulsed low while the FIFO holds 5 records -> out_valid=0 immediately, all counters 0, no stale records after reset release.
REQ-040 300 overflowing samples with out_ready=0 -> drop_count saturates at 255, overflow stays 1.
